// File: rtl/brick_hit_controller.sv
// Brick health memory writer: fills the grid at level start and serves hit
// requests as read-decrement-write cycles while tracking the live-brick count.
module brick_hit_controller #(
    parameter int GRID_W      = 10,
    parameter int GRID_H      = 8,
    parameter int ADDR_W      = 7,
    parameter int INIT_HEALTH = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init_start,
    output logic              init_done,
    input  logic              hit_req,
    input  logic [3:0]        hit_gx,
    input  logic [3:0]        hit_gy,
    output logic              hit_ready,
    output logic              hit_ack,
    output logic              hit_valid,
    output logic              brick_destroyed,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_data,
    output logic              mem_wren,
    input  logic [1:0]        mem_q,
    output logic [ADDR_W:0]   bricks_left,
    output logic              level_clear
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_EVAL, S_WR, S_MISS} state_t;

    localparam logic [31:0]       GW        = GRID_W;
    localparam logic [31:0]       GH        = GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
    localparam logic [ADDR_W:0]   N_BRICKS  = (ADDR_W + 1)'(GRID_W * GRID_H);
    localparam logic [ADDR_W:0]   ONE_B     = 1;
    localparam logic [1:0]        INIT_H    = 2'(INIT_HEALTH);

    state_t state, state_d;
    logic   initialized, initialized_d;
    logic   init_done_d, hit_ack_d, hit_valid_d, destroyed_d, wren_d, level_clear_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        data_d;
    logic [ADDR_W:0]   bricks_left_d;
    logic [ADDR_W-1:0] hit_lin;
    logic              hit_oob;

    assign hit_lin   = ADDR_W'(32'(hit_gy) * GW + 32'(hit_gx));
    assign hit_oob   = ({28'd0, hit_gx} >= GW) || ({28'd0, hit_gy} >= GH);
    assign hit_ready = (state == S_IDLE) && !init_start;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            initialized     <= 1'b0;
            init_done       <= 1'b0;
            hit_ack         <= 1'b0;
            hit_valid       <= 1'b0;
            brick_destroyed <= 1'b0;
            mem_address     <= '0;
            mem_data        <= '0;
            mem_wren        <= 1'b0;
            bricks_left     <= '0;
            level_clear     <= 1'b0;
        end else begin
            state           <= state_d;
            initialized     <= initialized_d;
            init_done       <= init_done_d;
            hit_ack         <= hit_ack_d;
            hit_valid       <= hit_valid_d;
            brick_destroyed <= destroyed_d;
            mem_address     <= addr_d;
            mem_data        <= data_d;
            mem_wren        <= wren_d;
            bricks_left     <= bricks_left_d;
            level_clear     <= level_clear_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (init_start)   state_d = S_FILL;
                else if (hit_req) state_d = hit_oob ? S_MISS : S_RD;
            end
            S_FILL:  if (mem_address == LAST_ADDR) state_d = S_IDLE;
            S_RD:    state_d = S_EVAL;
            S_EVAL:  state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            S_MISS:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so each state computes what the next cycle shows.
    // The WR-cycle response is decided from mem_q directly while in EVAL.
    always_comb begin
        initialized_d = initialized;
        init_done_d   = 1'b0;
        hit_ack_d     = 1'b0;
        hit_valid_d   = 1'b0;
        destroyed_d   = 1'b0;
        wren_d        = 1'b0;
        addr_d        = mem_address;
        data_d        = mem_data;
        bricks_left_d = bricks_left;
        case (state)
            S_IDLE: begin
                if (init_start) begin
                    wren_d        = 1'b1;
                    addr_d        = '0;
                    data_d        = INIT_H;
                    initialized_d = 1'b0;
                end else if (hit_req) begin
                    if (hit_oob) hit_ack_d = 1'b1;
                    else         addr_d    = hit_lin;
                end
            end
            S_FILL: begin
                if (mem_address == LAST_ADDR) begin
                    init_done_d   = 1'b1;
                    bricks_left_d = N_BRICKS;
                    initialized_d = 1'b1;
                end else begin
                    wren_d = 1'b1;
                    addr_d = mem_address + ADDR_W'(1);
                end
            end
            S_EVAL: begin
                hit_ack_d = 1'b1;
                if (mem_q != 2'd0) begin
                    wren_d      = 1'b1;
                    data_d      = mem_q - 2'd1;
                    hit_valid_d = 1'b1;
                end
                if (mem_q == 2'd1) begin
                    destroyed_d = 1'b1;
                    if (bricks_left != '0) bricks_left_d = bricks_left - ONE_B;
                end
            end
            default: ;
        endcase
        level_clear_d = initialized_d && (bricks_left_d == '0);
    end

endmodule

// File: tb/tb_brick_hit_controller.sv
// Scoreboard bench for brick_hit_controller: stimulus queues expected writes,
// acks and init completions; a negedge monitor pops and compares them.
module tb_brick_hit_controller;

    logic       clk = 1'b0;
    logic       resetn, init_start, hit_req;
    logic [3:0] hit_gx, hit_gy;
    logic       init_done, hit_ready, hit_ack, hit_valid, brick_destroyed, mem_wren, level_clear;
    logic [6:0] mem_address;
    logic [1:0] mem_data, mem_q;
    logic [7:0] bricks_left;

    brick_hit_controller dut (
        .clk(clk), .resetn(resetn), .init_start(init_start), .init_done(init_done),
        .hit_req(hit_req), .hit_gx(hit_gx), .hit_gy(hit_gy), .hit_ready(hit_ready),
        .hit_ack(hit_ack), .hit_valid(hit_valid), .brick_destroyed(brick_destroyed),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .bricks_left(bricks_left), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, 1-cycle latency
    logic [1:0] mem [0:127];
    initial for (int i = 0; i < 128; i++) mem[i] = 2'd0;
    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    typedef struct { int a; int d; } wexp_t;
    typedef struct { int v; int dst; int bl; } hexp_t;
    typedef struct { int bl; int lc; } iexp_t;
    wexp_t wq[$];
    hexp_t hq[$];
    iexp_t iq[$];

    int checks = 0, failures = 0;
    int ack_cnt = 0;
    int hm [0:79];
    int bl_m = 0;
    int last_addr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mem_wren) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                wexp_t w;
                w = wq.pop_front();
                chk("wr_addr", int'(mem_address), w.a);
                chk("wr_data", int'(mem_data), w.d);
            end
        end
        if (hit_ack) begin
            ack_cnt++;
            if (hq.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                hexp_t h;
                h = hq.pop_front();
                chk("ack_valid", int'(hit_valid), h.v);
                chk("ack_destroyed", int'(brick_destroyed), h.dst);
                chk("ack_bricks_left", int'(bricks_left), h.bl);
            end
        end
        if (init_done) begin
            if (iq.size() == 0) chk("unexpected_init_done", 1, 0);
            else begin
                iexp_t e;
                e = iq.pop_front();
                chk("init_bricks_left", int'(bricks_left), e.bl);
                chk("init_level_clear", int'(level_clear), e.lc);
            end
        end
    end

    task automatic do_hit(input int gx, input int gy);
        int a, h, lat, exp_lat;
        bit oob;
        hexp_t he;
        oob = (gx >= 10) || (gy >= 8);
        a = gy * 10 + gx;
        if (oob) begin
            he = '{0, 0, bl_m};
            exp_lat = 1;
        end else begin
            h = hm[a];
            if (h != 0) begin
                wq.push_back('{a, h - 1});
                hm[a] = h - 1;
            end
            if (h == 1 && bl_m > 0) bl_m--;
            he = '{(h != 0) ? 1 : 0, (h == 1) ? 1 : 0, bl_m};
            exp_lat = 3;
        end
        hq.push_back(he);
        chk("hit_ready_before", int'(hit_ready), 1);
        hit_req = 1'b1; hit_gx = 4'(gx); hit_gy = 4'(gy);
        @(negedge clk);
        hit_req = 1'b0;
        lat = 1;
        chk("t1_addr", int'(mem_address), oob ? last_addr : a);
        chk("t1_wren", int'(mem_wren), 0);
        if (!oob) last_addr = a;
        while (!hit_ack && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("hit_latency", lat, exp_lat);
        @(negedge clk);
        chk("hit_ready_after", int'(hit_ready), 1);
    endtask

    initial begin
        int n;
        resetn = 1'b0; init_start = 1'b0; hit_req = 1'b0; hit_gx = '0; hit_gy = '0;
        repeat (3) @(negedge clk);
        chk("rst_wren", int'(mem_wren), 0);
        chk("rst_addr", int'(mem_address), 0);
        chk("rst_bricks_left", int'(bricks_left), 0);
        chk("rst_level_clear", int'(level_clear), 0);
        chk("rst_ack", int'(hit_ack), 0);
        chk("rst_init_done", int'(init_done), 0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: grid fill
        for (int i = 0; i < 80; i++) begin
            wq.push_back('{i, 3});
            hm[i] = 3;
        end
        iq.push_back('{80, 0});
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        n = 1;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("init_latency", n, 81);
        chk("fill_writes_left", wq.size(), 0);
        chk("init_hit_ready", int'(hit_ready), 1);
        bl_m = 80;
        last_addr = 79;

        // 2-4: repeated hits on (2,1)
        do_hit(2, 1);
        chk("mem12_after1", int'(mem[12]), 2);
        do_hit(2, 1);
        do_hit(2, 1);
        chk("bricks_after_destroy", int'(bricks_left), 79);
        do_hit(2, 1);
        chk("bricks_after_dead_hit", int'(bricks_left), 79);

        // 5: out of range in each axis, then a corner cell
        do_hit(10, 0);
        do_hit(0, 8);
        do_hit(15, 15);
        do_hit(9, 7);
        chk("mem79", int'(mem[79]), 2);
        chk("level_clear_mid", int'(level_clear), 0);

        // Clear the whole level
        for (int c = 0; c < 80; c++)
            for (int k = 0; k < 3; k++)
                do_hit(c % 10, c / 10);
        chk("final_bricks_left", int'(bricks_left), 0);
        chk("level_clear_set", int'(level_clear), 1);
        chk("ack_queue_empty", hq.size(), 0);

        // 6: init_start beats hit_req, then reset mid-fill
        for (int i = 0; i <= 40; i++) wq.push_back('{i, 3});
        init_start = 1'b1; hit_req = 1'b1; hit_gx = 4'd3; hit_gy = 4'd3;
        #1;
        chk("ready_blocked_by_init", int'(hit_ready), 0);
        n = ack_cnt;
        @(negedge clk);
        init_start = 1'b0; hit_req = 1'b0;
        chk("fill_clears_level_clear", int'(level_clear), 0);
        repeat (40) @(negedge clk);
        chk("write40_addr", int'(mem_address), 40);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_wren", int'(mem_wren), 0);
        chk("rst_mid_bricks_left", int'(bricks_left), 0);
        chk("rst_mid_level_clear", int'(level_clear), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("dropped_hit_no_ack", ack_cnt, n);
        chk("writes_left_end", wq.size(), 0);
        chk("inits_left_end", iq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
